// File: rtl/cbud_pkg.sv
// Shared types and helpers for the cbud_mod up/down counter.
// Values are carried as 33-bit words so one helper serves every WIDTH up to 32.
package cbud_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef logic [32:0] cbud_word_t;

    function automatic cbud_word_t cbud_clamp(cbud_word_t d, cbud_word_t modulus);
        return (d >= modulus) ? modulus - 33'd1 : d;
    endfunction

    function automatic logic cbud_term(cbud_word_t q, logic dir, cbud_word_t modulus);
        return ((dir == DIR_UP) && (q == modulus - 33'd1)) || ((dir == DIR_DN) && (q == '0));
    endfunction

endpackage

// File: rtl/cbud_if.sv
// Control/data bundle for cbud_mod. CMP and MATCH exist only when CBUD_MATCH_EN is defined.
interface cbud_if
    import cbud_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             PS;
    logic             CS;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic             EN;
    logic             CAI;
    logic             DNUP;
    logic             OVFCLR;
    logic [WIDTH-1:0] Q;
    logic             CAO;
    logic             OVF;
`ifdef CBUD_MATCH_EN
    logic [WIDTH-1:0] CMP;
    logic             MATCH;

    modport master (output PS, CS, LD, D, EN, CAI, DNUP, OVFCLR, CMP,
                    input  Q, CAO, OVF, MATCH);
    modport slave  (input  PS, CS, LD, D, EN, CAI, DNUP, OVFCLR, CMP,
                    output Q, CAO, OVF, MATCH);
`else
    modport master (output PS, CS, LD, D, EN, CAI, DNUP, OVFCLR,
                    input  Q, CAO, OVF);
    modport slave  (input  PS, CS, LD, D, EN, CAI, DNUP, OVFCLR,
                    output Q, CAO, OVF);
`endif
endinterface

// File: rtl/cbud_next.sv
// Combinational next-state and terminal-value logic for cbud_mod.
module cbud_next
    import cbud_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int unsigned     SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ps,
    input  logic             cs,
    input  logic             ld,
    input  logic             cnt,
    input  logic             dnup,
    output logic [WIDTH-1:0] q_nxt,
    output logic             term
);
    localparam cbud_word_t       MOD_W = cbud_word_t'(MODULUS);
    localparam cbud_word_t       TOP_W = MOD_W - 33'd1;
    localparam logic [WIDTH-1:0] TOP   = TOP_W[WIDTH-1:0];
    localparam logic [WIDTH:0]   ONE   = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] step_w;

    always_comb begin
        step_w = (dnup == DIR_DN) ? {1'b0, q} - ONE : {1'b0, q} + ONE;
        term   = cbud_term(cbud_word_t'(q), dnup, MOD_W);
        q_nxt  = q;
        if (ps) begin
            q_nxt = TOP;
        end else if (cs) begin
            q_nxt = '0;
        end else if (ld) begin
            q_nxt = WIDTH'(cbud_clamp(cbud_word_t'(d), MOD_W));
        end else if (cnt && !(term && SATURATE != 0)) begin
            // Borrow out of zero or reaching MODULUS is the wrap point.
            if ((dnup == DIR_DN) && step_w[WIDTH]) begin
                q_nxt = TOP;
            end else if (step_w == MOD_W[WIDTH:0]) begin
                q_nxt = '0;
            end else begin
                q_nxt = step_w[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/cbud_mod.sv
// Cascadable up/down counter with programmable modulus, load, preset/clear and sticky OVF.
// Optional registered compare output MATCH is enabled with the CBUD_MATCH_EN macro.
module cbud_mod
    import cbud_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int unsigned     SATURATE = 0
) (
    input logic  CLK,
    input logic  RSTN,
    cbud_if.slave bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_q;
    logic             term;
    logic             cnt;
    logic             cao;
    logic             step;

    assign cnt = bus.CAI & bus.EN;

    cbud_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q     (q_q),
        .d     (bus.D),
        .ps    (bus.PS),
        .cs    (bus.CS),
        .ld    (bus.LD),
        .cnt   (cnt),
        .dnup  (bus.DNUP),
        .q_nxt (q_nxt),
        .term  (term)
    );

    // CAO ignores PS/CS/LD; a step event additionally requires none of them.
    assign cao  = cnt & term;
    assign step = cao & ~(bus.PS | bus.CS | bus.LD);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q <= q_nxt;
            if (step) begin
                ovf_q <= 1'b1;
            end else if (bus.OVFCLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.Q   = q_q;
    assign bus.CAO = cao;
    assign bus.OVF = ovf_q;

`ifdef CBUD_MATCH_EN
    logic match_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (q_nxt == bus.CMP);
        end
    end

    assign bus.MATCH = match_q;
`endif

endmodule

// File: tb/tb_cbud_mod.sv
// Self-checking bench for cbud_mod: directed table, saturate/cascade/match sequences,
// then randomized stimulus against an arithmetic reference model.
module tb_cbud_mod;
    localparam int M = 10;

    logic CLK;
    logic RSTN;

    cbud_if #(.WIDTH(4)) bi ();
    cbud_if #(.WIDTH(4)) bs ();
    cbud_if #(.WIDTH(4)) bl ();
    cbud_if #(.WIDTH(4)) bh ();

    cbud_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut (.CLK(CLK), .RSTN(RSTN), .bus(bi.slave));
    cbud_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (.CLK(CLK), .RSTN(RSTN), .bus(bs.slave));
    cbud_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo  (.CLK(CLK), .RSTN(RSTN), .bus(bl.slave));
    cbud_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi  (.CLK(CLK), .RSTN(RSTN), .bus(bh.slave));

    assign bh.CAI = bl.CAO;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rstn, ps, cs, ld;
        int d;
        bit en, cai, dn, oclr, chk_cao, cao;
        int q;
        bit ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rstn, bit ps, bit cs, bit ld, int d, bit en, bit cai, bit dn,
                                bit oclr, bit chk_cao, bit cao, int q, bit ovf);
        vec_t v;
        v = '{rstn, ps, cs, ld, d, en, cai, dn, oclr, chk_cao, cao, q, ovf};
        return v;
    endfunction

    // Reference model: spec rules expressed with modular integer arithmetic.
    function automatic bit model_cao(int q, bit en, bit cai, bit dn);
        return en && cai && ((!dn && q == M - 1) || (dn && q == 0));
    endfunction

    task automatic model_step(inout int q, inout bit ovf, input bit sat, input bit rstn,
                              input bit ps, input bit cs, input bit ld, input int d,
                              input bit en, input bit cai, input bit dn, input bit oclr);
        bit c;
        c = model_cao(q, en, cai, dn);
        if (!rstn) begin
            q   = 0;
            ovf = 0;
            return;
        end
        if (c && !(ps || cs || ld)) ovf = 1;
        else if (oclr) ovf = 0;
        if (ps) q = M - 1;
        else if (cs) q = 0;
        else if (ld) q = (d >= M) ? M - 1 : d;
        else if (en && cai && !(sat && c)) q = (q + (dn ? M - 1 : 1)) % M;
    endtask

    task automatic drive(ref vec_t v);
    endtask

    task automatic set_bus_main(input vec_t v);
        RSTN      = v.rstn;
        bi.PS     = v.ps;
        bi.CS     = v.cs;
        bi.LD     = v.ld;
        bi.D      = 4'(v.d);
        bi.EN     = v.en;
        bi.CAI    = v.cai;
        bi.DNUP   = v.dn;
        bi.OVFCLR = v.oclr;
    endtask

    task automatic sat_step(input bit ps, input bit cs, input bit en, input bit dn, input bit oclr,
                            input bit cao, input int q, input bit ovf);
        bs.PS = ps; bs.CS = cs; bs.EN = en; bs.CAI = en; bs.DNUP = dn; bs.OVFCLR = oclr;
        #2;
        check("sat_cao", bs.CAO, cao);
        @(posedge CLK); #1;
        check("sat_q", bs.Q, q);
        check("sat_ovf", bs.OVF, ovf);
    endtask

    int qm, qs;
    bit om, os;

    initial begin
        vec_t v;
        RSTN = 1'b0;
        bi.PS = 0; bi.CS = 0; bi.LD = 0; bi.D = 0; bi.EN = 0; bi.CAI = 0; bi.DNUP = 0; bi.OVFCLR = 0;
        bs.PS = 0; bs.CS = 0; bs.LD = 0; bs.D = 0; bs.EN = 0; bs.CAI = 0; bs.DNUP = 0; bs.OVFCLR = 0;
        bl.PS = 0; bl.CS = 0; bl.LD = 0; bl.D = 0; bl.EN = 0; bl.CAI = 0; bl.DNUP = 0; bl.OVFCLR = 0;
        bh.PS = 0; bh.CS = 0; bh.LD = 0; bh.D = 0; bh.EN = 0; bh.DNUP = 0; bh.OVFCLR = 0;
`ifdef CBUD_MATCH_EN
        bi.CMP = 4'hF; bs.CMP = 4'hF; bl.CMP = 4'hF; bh.CMP = 4'hF;
`endif

        // rstn ps cs ld d en cai dn oclr | chk cao | q ovf
        vecs.push_back(mk(0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 5, 1, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, ((i - 1) % 10) == 9, i % 10, i >= 10));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 9, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 9, 0));
        vecs.push_back(mk(1, 0, 0, 1, 3, 1, 1, 0, 0, 1, 1, 3, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3, 0, 0, 0, 0, 1, 0, 9, 0));
        vecs.push_back(mk(1, 0, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 12, 0, 0, 0, 0, 1, 0, 9, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 0, 0, 1, 15, 0, 0, 0, 0, 1, 0, 9, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 9, 0, 0, 0, 0, 1, 0, 9, 1));
        vecs.push_back(mk(0, 1, 0, 1, 7, 1, 1, 0, 0, 1, 1, 0, 0));

        @(posedge CLK); #1;
        foreach (vecs[k]) begin
            v = vecs[k];
            set_bus_main(v);
            #2;
            if (v.chk_cao) check($sformatf("tbl%0d_cao", k), bi.CAO, v.cao);
            @(posedge CLK); #1;
            check($sformatf("tbl%0d_q", k), bi.Q, v.q);
            check($sformatf("tbl%0d_ovf", k), bi.OVF, v.ovf);
        end
        RSTN = 1'b1;

        // Saturating instance: hold at both terminals while still flagging.
        sat_step(1, 0, 0, 0, 0, 0, 9, 0);
        for (int i = 0; i < 3; i++) sat_step(0, 0, 1, 0, 0, 1, 9, 1);
        sat_step(0, 1, 0, 0, 0, 0, 0, 1);
        sat_step(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) sat_step(0, 0, 1, 1, 0, 1, 0, 1);
        sat_step(0, 0, 0, 0, 1, 0, 0, 0);

        // Two-digit cascade: 25 counts from 00, OVFCLR overlaps a step on edge 20.
        bl.EN = 1; bl.CAI = 1; bh.EN = 1;
        for (int i = 1; i <= 25; i++) begin
            bl.OVFCLR = (i >= 15 && i <= 20);
            #2;
            check("casc_cao", bl.CAO, ((i - 1) % 10) == 9);
            @(posedge CLK); #1;
            check("casc_lo", bl.Q, i % 10);
            check("casc_hi", bh.Q, i / 10);
            check("casc_ovf", bl.OVF, (i >= 10 && i < 15) || i >= 20);
        end
        bl.EN = 0; bl.OVFCLR = 0; bh.EN = 0;
        check("casc_hi_ovf", bh.OVF, 0);

`ifdef CBUD_MATCH_EN
        bi.CMP = 4'd7; bi.CS = 1; bi.PS = 0; bi.LD = 0; bi.EN = 0; bi.CAI = 0; bi.DNUP = 0;
        bi.OVFCLR = 0;
        @(posedge CLK); #1;
        check("match_clr", bi.MATCH, 0);
        bi.CS = 0; bi.EN = 1; bi.CAI = 1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK); #1;
            check("match_q", bi.Q, k);
            check("match", bi.MATCH, k == 7);
        end
        bi.EN = 0;
        bi.CMP = 4'd8;
        #2;
        check("match_lag", bi.MATCH, 0);
        @(posedge CLK); #1;
        check("match_cmp8", bi.MATCH, 1);
`endif

        // Randomized phase: both wrap and saturate instances see identical stimulus.
        qm = 0; om = 0; qs = 0; os = 0;
        for (int n = 0; n < 500; n++) begin
            bit rstn, ps, cs, ld, en, cai, dn, oclr;
            int d;
            rstn = (n == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
            ps   = ($urandom_range(0, 15) == 0);
            cs   = ($urandom_range(0, 15) == 0);
            ld   = ($urandom_range(0, 7) == 0);
            d    = $urandom_range(0, 15);
            en   = ($urandom_range(0, 3) != 0);
            cai  = ($urandom_range(0, 3) != 0);
            dn   = (n % 40) >= 20 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            oclr = ($urandom_range(0, 7) == 0);
            RSTN = rstn;
            bi.PS = ps; bi.CS = cs; bi.LD = ld; bi.D = 4'(d); bi.EN = en; bi.CAI = cai;
            bi.DNUP = dn; bi.OVFCLR = oclr;
            bs.PS = ps; bs.CS = cs; bs.LD = ld; bs.D = 4'(d); bs.EN = en; bs.CAI = cai;
            bs.DNUP = dn; bs.OVFCLR = oclr;
            #2;
            if (n != 0) begin
                check("rnd_cao", bi.CAO, model_cao(qm, en, cai, dn));
                check("rnd_sat_cao", bs.CAO, model_cao(qs, en, cai, dn));
            end
            model_step(qm, om, 1'b0, rstn, ps, cs, ld, d, en, cai, dn, oclr);
            model_step(qs, os, 1'b1, rstn, ps, cs, ld, d, en, cai, dn, oclr);
            @(posedge CLK); #1;
            check("rnd_q", bi.Q, qm);
            check("rnd_ovf", bi.OVF, om);
            check("rnd_sat_q", bs.Q, qs);
            check("rnd_sat_ovf", bs.OVF, os);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cbud_mod.md
Name: cbud_mod

Overview:
- Parametrised N-bit up/down counter with programmable modulus, wrap or saturate mode, CAI/CAO cascade chaining, parallel load, synchronous preset/clear and a sticky overflow flag.
- Next-generation replacement for the fixed-width CBUDx counter macros.
- Used standalone or chained through CAI/CAO to build wide or mixed-radix counters, such as BCD digits or timers.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal values 2..2**WIDTH.
- SATURATE, 0, 0 = wrap at the terminal value, 1 = hold at the terminal value.

Ports:
- CLK  in  1  rising-edge clock.
- RSTN  in  1  synchronous active-low reset.
- PS  in  1  synchronous preset to MODULUS-1.
- CS  in  1  synchronous clear to 0.
- LD  in  1  synchronous parallel load of D.
- D  in  WIDTH  load data.
- EN  in  1  count enable.
- CAI  in  1  carry-in; counting requires CAI=1 and EN=1.
- DNUP  in  1  direction: 0 = up, 1 = down.
- OVFCLR  in  1  clears OVF.
- Q  out  WIDTH  count value, registered.
- CAO  out  1  carry-out, combinational.
- OVF  out  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset: the clock and reset are one clock, CLK, and a synchronous active-low reset, RSTN. On an edge with RSTN=0, Q=0 and OVF=0, overriding all other inputs. CAO=0 whenever Q is not at a terminal value or CAI&EN=0.
- Per-edge priority when RSTN=1: PS > CS > LD > count > hold.
  - PS: Q=MODULUS-1.
  - CS: Q=0.
  - LD: Q=D. If D>=MODULUS, Q=MODULUS-1 (clamp).
  - Count: applies when CAI&EN=1.
    - Up: Q+1; at Q=MODULUS-1, wrap to 0, or hold when SATURATE=1.
    - Down: Q-1; at Q=0, wrap to MODULUS-1, or hold when SATURATE=1.
- Terminal values: TERM = (DNUP=0 & Q==MODULUS-1) | (DNUP=1 & Q==0).
- CAO = CAI & EN & TERM. It is combinational, zero latency, and identical in both modes. It does not depend on PS, CS or LD; downstream stages gate on their own controls.
- Step event: CAO=1 and no PS, CS or LD on that edge.
  - A step event sets OVF on the same edge.
  - OVFCLR=1 clears OVF.
  - When a step event and OVFCLR coincide, the set wins.
  - PS, CS and LD do not touch OVF.
- Out-of-range state: Q cannot exceed MODULUS-1 by construction; no illegal state is reachable after reset.
- Arithmetic: done in WIDTH+1 bits internally. With MODULUS=2**WIDTH, the wrap reduces to natural modulo arithmetic.
- DNUP may change every cycle. Direction is sampled on the same edge as the count.
- Asserting RSTN mid-count takes effect on the next edge regardless of CAI, EN, LD or PS.

Optional Feature:
- Macro CBUD_MATCH_EN.
- When defined, the block adds input CMP[WIDTH] and output MATCH (registered, reset 0).
  - MATCH is computed from the next-state value, so MATCH=1 in exactly the cycles where Q==CMP.
  - A change on CMP is reflected in MATCH one edge later.
- When undefined, the CMP and MATCH ports and their logic are absent.

Decomposition:
- Package cbud_pkg holds:
  - localparams DIR_UP=1'b0 and DIR_DN=1'b1;
  - function cbud_clamp(d, modulus);
  - function cbud_term(q, dir, modulus).
- One sub-module, cbud_next, is natural: purely combinational next-state plus TERM computation. The top keeps the Q, OVF and MATCH registers.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
1. Reset: hold RSTN=0 for 2 edges with PS=LD=EN=CAI=1 -> Q=0, OVF=0. Then RSTN=1 with PS=1 -> Q=9 after 1 edge.
2. Up wrap: Q=0, EN=CAI=1, DNUP=0, 12 edges -> Q goes 1..9,0,1,2. CAO=1 only while Q=9. OVF=1 from the edge where Q goes 9->0. OVFCLR pulse -> OVF=0.
3. Down wrap and priority:
   - LD=1, D=0 -> Q=0, then count down -> Q=9 and OVF set.
   - PS=CS=LD=1, D=3 -> Q=9.
   - CS=LD=1 -> Q=0.
   - LD=1, D=12 -> Q=9 (clamp).
4. Saturate (SATURATE=1): Q=9 counting up for 3 edges -> Q stays 9, CAO=1, OVF=1. DNUP=1 from Q=0 -> Q stays 0.
5. Cascade: two instances, low CAO -> high CAI, common EN=1, start 00, 25 edges up -> {hi,lo}=2,5. hi steps exactly on the edges where lo goes 9->0. Same edge carries OVFCLR=1 and a step event -> OVF=1.
6. CBUD_MATCH_EN: CMP=7, count up from 0 -> MATCH=1 exactly in the cycle Q=7. Change CMP to 8 while Q=8 -> MATCH=1 after 1 edge.
